// File: rtl/usb_multi_ep_protocol_ctrl.sv
// Bulk IN/OUT protocol controller for NUM_EP endpoints sharing one data buffer.
// Define PC_DATA_TOGGLE_EN to add per-endpoint DATA0/DATA1 tracking and duplicate OUT detection.

`ifdef PC_DATA_TOGGLE_EN
module usb_ep_toggle (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic flip,
    output logic q
);
    // A clear beats a flip landing on the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       q <= 1'b0;
        else if (clr)  q <= 1'b0;
        else if (flip) q <= ~q;
    end
endmodule
`endif

module usb_multi_ep_protocol_ctrl #(
    parameter int NUM_EP  = 4,
    parameter int MAX_PKT = 64,
    parameter int OCC_W   = 7,
    parameter int TIMEOUT = 32,
    parameter int EP_W    = (NUM_EP > 1) ? $clog2(NUM_EP) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        rx_packet,
    input  logic [EP_W-1:0]   rx_endp,
    input  logic              rx_data1,
    input  logic [OCC_W-1:0]  buffer_occupancy,
    input  logic [OCC_W-1:0]  tx_packet_data_size,
    input  logic              buffer_reserved,
`ifdef PC_DATA_TOGGLE_EN
    input  logic [NUM_EP-1:0] toggle_clr,
`endif
    output logic [1:0]        tx_packet,
    output logic              tx_data1,
    output logic              tx_transfer_active,
    output logic              tx_error,
    output logic              rx_transfer_active,
    output logic              rx_data_ready,
    output logic              rx_error,
    output logic              d_mode,
    output logic              clear,
    output logic [EP_W-1:0]   active_ep
);
    typedef enum logic [3:0] {
        S_IDLE, S_RESERVED, S_IN_WAIT, S_IN_MODE, S_IN_NAK,
        S_OUT_MODE, S_OUT_ERR, S_OUT_ACK, S_OUT_NAK
    } state_t;

    localparam logic [2:0] RX_IN    = 3'd1;
    localparam logic [2:0] RX_OUT   = 3'd2;
    localparam logic [2:0] RX_ACK   = 3'd3;
    localparam logic [2:0] RX_ERROR = 3'd4;
    localparam logic [2:0] RX_DONE  = 3'd5;

    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_DATA = 2'd1;
    localparam logic [1:0] TX_NAK  = 2'd2;
    localparam logic [1:0] TX_ACK  = 2'd3;

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(MAX_PKT);

    state_t           state_q, state_d;
    logic [EP_W-1:0]  ep_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
    logic             dup;
    logic             ep_ok, in_tok, out_tok, is_ack, is_err, is_done, oversize;

    // Tokens addressed to a nonexistent endpoint are dropped entirely.
    assign ep_ok    = ({1'b0, rx_endp} < (EP_W+1)'(NUM_EP));
    assign in_tok   = (rx_packet == RX_IN)  && ep_ok;
    assign out_tok  = (rx_packet == RX_OUT) && ep_ok;
    assign is_ack   = (rx_packet == RX_ACK);
    assign is_err   = (rx_packet == RX_ERROR);
    assign is_done  = (rx_packet == RX_DONE);
    assign oversize = (buffer_occupancy > OCC_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            active_ep <= '0;
            cnt_q     <= '0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            active_ep <= ep_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ep_d    = active_ep;
        cnt_d   = '0;
        tmo_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_tok)
                    state_d = S_IN_NAK;
                else if (buffer_reserved)
                    state_d = S_RESERVED;
                else if (out_tok) begin
                    if (buffer_occupancy != '0)
                        state_d = S_OUT_NAK;
                    else begin
                        state_d = S_OUT_MODE;
                        ep_d    = rx_endp;
                    end
                end
            end
            S_RESERVED: begin
                if (in_tok)
                    state_d = S_IN_NAK;
                else if ((buffer_occupancy == tx_packet_data_size) && (tx_packet_data_size != '0))
                    state_d = S_IN_WAIT;
                else if (!buffer_reserved)
                    state_d = S_IDLE;
            end
            S_IN_WAIT: begin
                if (in_tok) begin
                    state_d = S_IN_MODE;
                    ep_d    = rx_endp;
                end else if (out_tok)
                    state_d = S_OUT_NAK;
            end
            S_IN_MODE: begin
                // ACK is checked first so a last-cycle ACK still completes the transfer.
                if (is_ack)
                    state_d = S_IDLE;
                else if (cnt_q == CNT_LAST) begin
                    state_d = S_IN_WAIT;
                    tmo_d   = 1'b1;
                end else
                    cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
            end
            S_OUT_MODE: begin
                if (is_err || oversize)
                    state_d = S_OUT_ERR;
                else if (is_done)
                    state_d = S_OUT_ACK;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef PC_DATA_TOGGLE_EN
    localparam int EP_N = 1 << EP_W;

    logic [EP_N-1:0] toggle_q;
    logic            dup_q, dup_d, flip_ev;

    assign dup_d   = (rx_data1 != toggle_q[active_ep]);
    assign flip_ev = ((state_q == S_IN_MODE) && is_ack) ||
                     ((state_q == S_OUT_MODE) && (state_d == S_OUT_ACK) && !dup_d);

    for (genvar i = 0; i < EP_N; i++) begin : g_tog
        if (i < NUM_EP) begin : g_cell
            usb_ep_toggle u_tog (
                .clk  (clk),
                .rst  (rst),
                .clr  (toggle_clr[i]),
                .flip (flip_ev && (active_ep == EP_W'(i))),
                .q    (toggle_q[i])
            );
        end else begin : g_pad
            assign toggle_q[i] = 1'b0;
        end
    end

    // PID mismatch on DONE is captured so OUT_ACK can re-ACK without delivering data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      dup_q <= 1'b0;
        else if (state_d == S_OUT_ACK) dup_q <= dup_d;
    end

    assign dup      = dup_q;
    assign tx_data1 = toggle_q[active_ep];
`else
    logic unused_rx_data1;
    assign unused_rx_data1 = rx_data1;
    assign dup      = 1'b0;
    assign tx_data1 = 1'b0;
`endif

    always_comb begin
        tx_packet          = TX_IDLE;
        tx_transfer_active = 1'b0;
        tx_error           = tmo_q;
        rx_transfer_active = 1'b0;
        rx_data_ready      = 1'b0;
        rx_error           = 1'b0;
        d_mode             = 1'b0;
        clear              = 1'b0;
        case (state_q)
            S_IN_MODE: begin
                tx_packet          = TX_DATA;
                tx_transfer_active = 1'b1;
            end
            S_IN_NAK: begin
                tx_packet = TX_NAK;
                tx_error  = 1'b1;
            end
            S_OUT_MODE: begin
                d_mode             = 1'b1;
                rx_transfer_active = 1'b1;
            end
            S_OUT_ERR: begin
                clear    = 1'b1;
                rx_error = 1'b1;
                d_mode   = 1'b1;
            end
            S_OUT_ACK: begin
                tx_packet     = TX_ACK;
                rx_data_ready = ~dup;
                clear         = dup;
            end
            S_OUT_NAK: begin
                tx_packet = TX_NAK;
                rx_error  = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_usb_multi_ep_protocol_ctrl.sv
// Directed plus randomized transaction bench for usb_multi_ep_protocol_ctrl.
module tb_usb_multi_ep_protocol_ctrl;
    localparam int NUM_EP  = 4;
    localparam int EP_W    = 2;
    localparam int MAX_PKT = 64;
    localparam int OCC_W   = 7;
    localparam int TIMEOUT = 32;
`ifdef PC_DATA_TOGGLE_EN
    localparam bit TOG_EN = 1'b1;
`else
    localparam bit TOG_EN = 1'b0;
`endif

    localparam int P_IDLE = 0, P_IN = 1, P_OUT = 2, P_ACK = 3, P_ERROR = 4, P_DONE = 5;

    logic              clk, rst;
    logic [2:0]        rx_packet;
    logic [EP_W-1:0]   rx_endp;
    logic              rx_data1;
    logic [OCC_W-1:0]  buffer_occupancy, tx_packet_data_size;
    logic              buffer_reserved;
    logic [NUM_EP-1:0] toggle_clr;
    logic [1:0]        tx_packet;
    logic              tx_data1, tx_transfer_active, tx_error, rx_transfer_active;
    logic              rx_data_ready, rx_error, d_mode, clear;
    logic [EP_W-1:0]   active_ep;

    int checks   = 0;
    int failures = 0;
    bit tog [NUM_EP];

    usb_multi_ep_protocol_ctrl #(
        .NUM_EP(NUM_EP), .MAX_PKT(MAX_PKT), .OCC_W(OCC_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rx_packet           (rx_packet),
        .rx_endp             (rx_endp),
        .rx_data1            (rx_data1),
        .buffer_occupancy    (buffer_occupancy),
        .tx_packet_data_size (tx_packet_data_size),
        .buffer_reserved     (buffer_reserved),
`ifdef PC_DATA_TOGGLE_EN
        .toggle_clr          (toggle_clr),
`endif
        .tx_packet           (tx_packet),
        .tx_data1            (tx_data1),
        .tx_transfer_active  (tx_transfer_active),
        .tx_error            (tx_error),
        .rx_transfer_active  (rx_transfer_active),
        .rx_data_ready       (rx_data_ready),
        .rx_error            (rx_error),
        .d_mode              (d_mode),
        .clear               (clear),
        .active_ep           (active_ep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of run, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Output bundle: {tx_packet, txa, txe, rxa, rdy, rxe, d_mode, clear}
    function automatic logic [8:0] mk(input logic [1:0] tp, input logic txa, txe, rxa, rdy, rxe, dm, clr);
        return {tp, txa, txe, rxa, rdy, rxe, dm, clr};
    endfunction

    function automatic logic [8:0] outs();
        return {tx_packet, tx_transfer_active, tx_error, rx_transfer_active,
                rx_data_ready, rx_error, d_mode, clear};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_o(input string tag, input logic [8:0] exp);
        chk(tag, {23'd0, outs()}, {23'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load-and-send IN transaction; ACK arrives on the d-th cycle of SEND_DATA,
    // counting across retries, so d > TIMEOUT forces one or more timeouts.
    task automatic in_xact(input int ep, input int size, input int d);
        int  left;
        bit  done;
        buffer_reserved = 1'b1; tx_packet_data_size = OCC_W'(size);
        buffer_occupancy = '0; rx_packet = 3'(P_IDLE);
        tick(); chk_o("in_reserved", mk(0,0,0,0,0,0,0,0));
        buffer_occupancy = OCC_W'(size);
        tick(); chk_o("in_wait", mk(0,0,0,0,0,0,0,0));
        buffer_reserved = 1'b0;
        left = d;
        done = 1'b0;
        while (!done) begin
            rx_packet = 3'(P_IN); rx_endp = EP_W'(ep);
            tick(); rx_packet = 3'(P_IDLE);
            chk_o("in_send", mk(1,1,0,0,0,0,0,0));
            chk("in_active_ep", 32'(active_ep), 32'(ep));
            chk("in_pid", 32'(tx_data1), 32'(tog[ep]));
            for (int j = 1; j <= TIMEOUT; j++) begin
                if (j == left) begin
                    rx_packet = 3'(P_ACK);
                    tick(); rx_packet = 3'(P_IDLE);
                    chk_o("in_acked", mk(0,0,0,0,0,0,0,0));
                    if (TOG_EN) tog[ep] = ~tog[ep];
                    chk("in_pid_after_ack", 32'(tx_data1), 32'(tog[ep]));
                    done = 1'b1;
                    break;
                end
                tick();
                if (j < TIMEOUT) chk_o("in_hold", mk(1,1,0,0,0,0,0,0));
                else             chk_o("in_timeout", mk(0,0,1,0,0,0,0,0));
            end
            if (!done) begin
                left -= TIMEOUT;
                tick(); chk_o("in_wait_retry", mk(0,0,0,0,0,0,0,0));
            end
        end
    endtask

    // OUT token on an empty buffer, then a terminating packet with occupancy occ.
    task automatic out_xact(input int ep, input int occ, input bit pid, input int pkt);
        bit dup;
        buffer_occupancy = '0; rx_packet = 3'(P_OUT); rx_endp = EP_W'(ep);
        tick(); rx_packet = 3'(P_IDLE);
        chk_o("out_mode", mk(0,0,0,1,0,0,1,0));
        chk("out_active_ep", 32'(active_ep), 32'(ep));
        buffer_occupancy = OCC_W'(occ); rx_data1 = pid; rx_packet = 3'(pkt);
        tick(); rx_packet = 3'(P_IDLE);
        if (pkt == P_ERROR || occ > MAX_PKT)
            chk_o("out_err", mk(0,0,0,0,0,1,1,1));
        else begin
            dup = TOG_EN && (pid != tog[ep]);
            chk_o("out_ack", mk(3,0,0,0,!dup,0,0,dup));
            if (TOG_EN && !dup) tog[ep] = ~tog[ep];
        end
        buffer_occupancy = '0;
        tick(); chk_o("out_idle", mk(0,0,0,0,0,0,0,0));
        chk("out_pid", 32'(tx_data1), 32'(tog[ep]));
    endtask

    task automatic out_nak(input int ep, input int occ);
        buffer_occupancy = OCC_W'(occ); rx_packet = 3'(P_OUT); rx_endp = EP_W'(ep);
        tick(); rx_packet = 3'(P_IDLE);
        chk_o("out_nak", mk(2,0,0,0,0,1,0,0));
        buffer_occupancy = '0;
        tick(); chk_o("out_nak_idle", mk(0,0,0,0,0,0,0,0));
    endtask

    task automatic in_nak(input int ep);
        rx_packet = 3'(P_IN); rx_endp = EP_W'(ep);
        tick(); rx_packet = 3'(P_IDLE);
        chk_o("in_nak", mk(2,0,1,0,0,0,0,0));
        tick(); chk_o("in_nak_idle", mk(0,0,0,0,0,0,0,0));
    endtask

    initial begin
        rst = 1'b1; rx_packet = '0; rx_endp = '0; rx_data1 = 1'b0;
        buffer_occupancy = '0; tx_packet_data_size = '0; buffer_reserved = 1'b0;
        toggle_clr = '0;
        foreach (tog[i]) tog[i] = 1'b0;

        tick();
        chk_o("reset_outs", mk(0,0,0,0,0,0,0,0));
        chk("reset_ep", 32'(active_ep), 32'd0);
        chk("reset_pid", 32'(tx_data1), 32'd0);
        rst = 1'b0;

        // Basic IN on ep2, then ACK exactly on the last allowed cycle, then a timeout with retry.
        in_xact(2, 8, 3);
        in_xact(2, 8, TIMEOUT);
        in_xact(1, 16, TIMEOUT + 1);

        // OUT on ep1 twice with the same PID; second is a duplicate when toggles are tracked.
        out_xact(1, 10, 1'b0, P_DONE);
        out_xact(1, 10, 1'b0, P_DONE);
        out_xact(3, 65, 1'b0, P_IDLE);
        out_xact(0, MAX_PKT, 1'b0, P_DONE);
        out_xact(0, 5, 1'b1, P_ERROR);

        out_nak(0, 5);
        in_nak(3);

`ifdef PC_DATA_TOGGLE_EN
        toggle_clr = 4'b0100;
        tick(); toggle_clr = '0;
        tog[2] = 1'b0;
        rx_endp = 2'd2;
        in_xact(2, 4, 1);
`endif

        // Asynchronous reset in the middle of SEND_DATA.
        buffer_reserved = 1'b1; tx_packet_data_size = 7'd4; buffer_occupancy = '0;
        tick();
        buffer_occupancy = 7'd4;
        tick();
        buffer_reserved = 1'b0; rx_packet = 3'(P_IN); rx_endp = 2'd3;
        tick(); rx_packet = 3'(P_IDLE);
        chk_o("pre_reset_send", mk(1,1,0,0,0,0,0,0));
        #2 rst = 1'b1;
        #1 chk_o("async_reset_outs", mk(0,0,0,0,0,0,0,0));
        chk("async_reset_ep", 32'(active_ep), 32'd0);
        foreach (tog[i]) tog[i] = 1'b0;
        tick(); rst = 1'b0; buffer_occupancy = '0;
        tick();
        chk_o("post_reset_idle", mk(0,0,0,0,0,0,0,0));
        chk("post_reset_pid", 32'(tx_data1), 32'd0);

        for (int n = 0; n < 40; n++) begin
            int k, ep;
            k  = $urandom_range(0, 9);
            ep = $urandom_range(0, NUM_EP - 1);
            if (k < 4)
                in_xact(ep, $urandom_range(1, MAX_PKT), $urandom_range(1, TIMEOUT + 8));
            else if (k < 8)
                out_xact(ep, $urandom_range(1, 70), 1'($urandom_range(0, 1)),
                         ($urandom_range(0, 4) == 0) ? P_ERROR : P_DONE);
            else if (k == 8)
                out_nak(ep, $urandom_range(1, MAX_PKT));
            else
                in_nak(ep);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
